// File: rtl/button_conditioner.sv
// Per-button debounce and event generator: synchronizes raw pins, then emits a clean level plus
// press, release, long-press and auto-repeat pulses timed by an external sample tick.
module button_conditioner #(
  parameter int unsigned N              = 2,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 500,
  parameter int unsigned REPEAT_TICKS   = 100
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         ena,
  input  logic         step,
  input  logic [N-1:0] buttons_raw,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse,
  output logic [N-1:0] repeat_pulse
);

  localparam int unsigned MaxDbLong = (DEBOUNCE_TICKS > LONG_TICKS) ? DEBOUNCE_TICKS : LONG_TICKS;
  localparam int unsigned MaxTicks  = (MaxDbLong > REPEAT_TICKS) ? MaxDbLong : REPEAT_TICKS;
  localparam int unsigned CNT_W     = $clog2(MaxTicks + 1);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StHeld,
    StRepeat,
    StDbRelease
  } state_e;

  logic [N-1:0]     sync1_q, sync2_q;
  state_e           state_q [N];
  state_e           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic             tick;

  logic [N-1:0] pressed_q, pressed_d;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] release_q, release_d;
  logic [N-1:0] long_q, long_d;
  logic [N-1:0] repeat_q, repeat_d;

  // Two-flop synchronizer; runs regardless of ena.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons_raw;
      sync2_q <= sync1_q;
    end
  end

  assign tick = ena & step;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // A change of the synced level always wins over a tick in the same cycle.
  always_comb begin
    pressed_d = '0;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (ena) begin
        case (state_q[i])
          StIdle: begin
            if (sync2_q[i]) begin
              state_d[i] = StDbPress;
              cnt_d[i]   = '0;
            end
          end
          StDbPress: begin
            if (!sync2_q[i]) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else if (tick) begin
              if (cnt_q[i] == DbLast) begin
                state_d[i] = StHeld;
                cnt_d[i]   = '0;
                press_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
              end
            end
          end
          StHeld: begin
            if (!sync2_q[i]) begin
              state_d[i] = StDbRelease;
              cnt_d[i]   = '0;
            end else if (tick) begin
              if (cnt_q[i] == LongLast) begin
                state_d[i] = StRepeat;
                cnt_d[i]   = '0;
                long_d[i]  = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
              end
            end
          end
          StRepeat: begin
            if (!sync2_q[i]) begin
              state_d[i] = StDbRelease;
              cnt_d[i]   = '0;
            end else if (tick) begin
              if (cnt_q[i] == RepLast) begin
                cnt_d[i]    = '0;
                repeat_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
              end
            end
          end
          StDbRelease: begin
            if (sync2_q[i]) begin
              state_d[i] = StHeld;
              cnt_d[i]   = '0;
            end else if (tick) begin
              if (cnt_q[i] == DbLast) begin
                state_d[i]   = StIdle;
                cnt_d[i]     = '0;
                release_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
              end
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end
        endcase
      end
      pressed_d[i] = (state_d[i] == StHeld) || (state_d[i] == StRepeat) ||
                     (state_d[i] == StDbRelease);
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: table of hold lengths plus hand-written sequences for
// bounce, long hold, release glitch, ena freeze, reset mid-hold and button independence.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int unsigned N  = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned LT = 10;
  localparam int unsigned RT = 3;

  logic         clk  = 1'b0;
  logic         rstb = 1'b1;
  logic         ena  = 1'b1;
  logic         step = 1'b0;
  logic [N-1:0] buttons_raw = '0;
  logic [N-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

  button_conditioner #(
    .N              (N),
    .DEBOUNCE_TICKS (DB),
    .LONG_TICKS     (LT),
    .REPEAT_TICKS   (RT)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .ena           (ena),
    .step          (step),
    .buttons_raw   (buttons_raw),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick   = 0;
  int cyc    = 0;
  int press_tot [N] = '{default: 0};
  int rel_tot   [N] = '{default: 0};
  int long_tot  [N] = '{default: 0};
  int rep_tot   [N] = '{default: 0};
  int press_tick[N] = '{default: 0};
  int press_cyc [N] = '{default: 0};
  int long_tick [N] = '{default: 0};
  int rep_tick  [N][64];

  // Step generator: one clk high every 4 clk, changed just after the rising edge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      step = (ph == 3);
      ph   = (ph + 1) % 4;
    end
  end

  // Event monitor: tick counts effective ticks, pulses are tagged with the tick that caused them.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (press_pulse[i]) begin
          press_tot[i]++;
          press_tick[i] = tick;
          press_cyc[i]  = cyc;
        end
        if (release_pulse[i]) rel_tot[i]++;
        if (long_pulse[i]) begin
          long_tot[i]++;
          long_tick[i] = tick;
        end
        if (repeat_pulse[i]) begin
          if (rep_tot[i] < 64) rep_tick[i][rep_tot[i]] = tick;
          rep_tot[i]++;
        end
      end
      if (ena && step && rstb) tick++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!step) @(negedge clk);
    end
  endtask

  function automatic int total(input int kind, input int b);
    case (kind)
      0:       return press_tot[b];
      1:       return rel_tot[b];
      2:       return long_tot[b];
      default: return rep_tot[b];
    endcase
  endfunction

  task automatic wait_event(input string name, input int kind, input int b, input int base,
                            input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (total(kind, b) > base) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  typedef struct {
    int btn;
    int hold;
    int e_press;
    int e_rel;
    int e_long;
    int e_rep;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bp, br, bl, bq, bp1, br1, bl1, bq1, c0, ref_tick, res_tick;
    // Hold lengths chosen so the result is independent of step phase.
    vecs[0] = '{0, 1,  0, 0, 0, 0};
    vecs[1] = '{0, 3,  0, 0, 0, 0};
    vecs[2] = '{0, 6,  1, 1, 0, 0};
    vecs[3] = '{1, 12, 1, 1, 0, 0};
    vecs[4] = '{0, 16, 1, 1, 1, 0};
    vecs[5] = '{1, 22, 1, 1, 1, 2};

    #1 rstb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pressed", int'(pressed), 0);
    check("reset_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press, held 40 clk.
    bp = press_tot[0]; br = rel_tot[0];
    c0 = cyc;
    buttons_raw[0] = 1'b1;
    wait_event("clean_press_wait", 0, 0, bp, 40);
    check_range("clean_press_latency", press_cyc[0] - c0, 16, 19);
    check("clean_pressed_hi", int'(pressed[0]), 1);
    repeat (20) @(negedge clk);
    buttons_raw[0] = 1'b0;
    tick_wait(8);
    check("clean_press_count", press_tot[0] - bp, 1);
    check("clean_release_count", rel_tot[0] - br, 1);
    check("clean_pressed_lo", int'(pressed[0]), 0);

    foreach (vecs[v]) begin
      int b;
      b  = vecs[v].btn;
      bp = press_tot[b]; br = rel_tot[b]; bl = long_tot[b]; bq = rep_tot[b];
      buttons_raw[b] = 1'b1;
      tick_wait(vecs[v].hold);
      buttons_raw[b] = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_pressed_hold", v), int'(pressed[b]), vecs[v].e_press);
      tick_wait(8);
      check($sformatf("vec%0d_press", v), press_tot[b] - bp, vecs[v].e_press);
      check($sformatf("vec%0d_release", v), rel_tot[b] - br, vecs[v].e_rel);
      check($sformatf("vec%0d_long", v), long_tot[b] - bl, vecs[v].e_long);
      check($sformatf("vec%0d_repeat", v), rep_tot[b] - bq, vecs[v].e_rep);
      check($sformatf("vec%0d_pressed_end", v), int'(pressed[b]), 0);
    end

    // Bounce: high 2 ticks, low 1, high 1, low.
    bp = press_tot[0]; br = rel_tot[0];
    buttons_raw[0] = 1'b1; tick_wait(2);
    buttons_raw[0] = 1'b0; tick_wait(1);
    buttons_raw[0] = 1'b1; tick_wait(1);
    buttons_raw[0] = 1'b0; tick_wait(6);
    check("bounce_press", press_tot[0] - bp, 0);
    check("bounce_release", rel_tot[0] - br, 0);
    check("bounce_pressed", int'(pressed[0]), 0);

    // Long hold: 23 ticks past press.
    bp = press_tot[0]; br = rel_tot[0]; bl = long_tot[0]; bq = rep_tot[0];
    buttons_raw[0] = 1'b1;
    wait_event("long_press_wait", 0, 0, bp, 40);
    tick_wait(23);
    buttons_raw[0] = 1'b0;
    tick_wait(8);
    check("long_count", long_tot[0] - bl, 1);
    check("long_tick", long_tick[0] - press_tick[0], 10);
    check("repeat_count", rep_tot[0] - bq, 4);
    for (int j = 0; j < 4; j++)
      check($sformatf("repeat%0d_tick", j), rep_tick[0][bq + j] - press_tick[0], 13 + 3 * j);
    check("long_release", rel_tot[0] - br, 1);
    tick_wait(6);
    check("repeat_after_release", rep_tot[0] - bq, 4);

    // Release glitch in HELD at tick 6.
    bp = press_tot[0]; br = rel_tot[0]; bl = long_tot[0];
    buttons_raw[0] = 1'b1;
    wait_event("glitch_press_wait", 0, 0, bp, 40);
    tick_wait(6);
    buttons_raw[0] = 1'b0;
    tick_wait(1);
    buttons_raw[0] = 1'b1;
    ref_tick = tick;
    wait_event("glitch_long_wait", 2, 0, bl, 80);
    check_range("glitch_long_tick", long_tick[0] - ref_tick, 10, 11);
    check("glitch_long_count", long_tot[0] - bl, 1);
    check("glitch_no_release", rel_tot[0] - br, 0);
    check("glitch_pressed", int'(pressed[0]), 1);
    buttons_raw[0] = 1'b0;
    tick_wait(8);

    // ena freeze during DB_PRESS, then reset mid-REPEAT.
    bp = press_tot[0];
    buttons_raw[0] = 1'b1;
    tick_wait(2);
    @(negedge clk);
    ena = 1'b0;
    tick_wait(20);
    check("freeze_no_press", press_tot[0] - bp, 0);
    check("freeze_pressed", int'(pressed[0]), 0);
    @(negedge clk);
    ena = 1'b1;
    res_tick = tick;
    wait_event("resume_press_wait", 0, 0, bp, 40);
    check_range("resume_press_ticks", press_tick[0] - res_tick, 2, 3);
    bq = rep_tot[0];
    wait_event("reset_repeat_wait", 3, 0, bq, 120);
    @(negedge clk);
    br = rel_tot[0];
    rstb = 1'b0;
    #1;
    check("rst_mid_pressed", int'(pressed), 0);
    check("rst_mid_pulses", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    buttons_raw = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    tick_wait(8);
    check("rst_no_release", rel_tot[0] - br, 0);
    check("rst_pressed_after", int'(pressed[0]), 0);

    // Independence: simultaneous press, then hold only bit 1.
    bp = press_tot[0]; bl = long_tot[0]; bq = rep_tot[0];
    bp1 = press_tot[1]; br1 = rel_tot[1]; bl1 = long_tot[1]; bq1 = rep_tot[1];
    br = rel_tot[0];
    buttons_raw = 2'b11;
    wait_event("indep_press_wait", 0, 1, bp1, 40);
    check("indep_press0", press_tot[0] - bp, 1);
    check("indep_same_cycle", press_cyc[0] - press_cyc[1], 0);
    buttons_raw = 2'b10;
    tick_wait(20);
    buttons_raw = 2'b00;
    tick_wait(8);
    check("indep_long0", long_tot[0] - bl, 0);
    check("indep_long1", long_tot[1] - bl1, 1);
    check("indep_rep0", rep_tot[0] - bq, 0);
    check("indep_rep1", rep_tot[1] - bq1, 3);
    check("indep_rel0", rel_tot[0] - br, 1);
    check("indep_rel1", rel_tot[1] - br1, 1);
    check("indep_pressed_end", int'(pressed), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
